// File: rtl/elelock_ctrl.sv
// Tenkey lock sequencer: debounced-edge digit capture, code check, retry limit/lockout, auto-relock.
// Latency: last digit sampled at edge T -> CHECK during T..T+1 -> unlock_p/fail_p/lock updated at edge T+1.
// Backpressure: none; at most one digit per cycle, presses outside LOCKED (or with close) are dropped.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   tenkey[9:0]       raw key levels, bit i = digit i (synchronous to clk)
//   close             level; re-lock when open, clear partial entry when locked
//   lock              registered, 1 = locked
//   unlock_p, fail_p  one-cycle result pulses
//   lockout           high while retries are exhausted
//   tries_left[3:0]   remaining attempts before lockout
module elelock_ctrl #(
    parameter int          CODE_LEN     = 4,
    parameter logic [15:0] SECRET       = 16'h3719,
    parameter int          MAX_TRIES    = 3,
    parameter int          LOCKOUT_CYC  = 1000,
    parameter int          RELOCK_CYC   = 500,
    parameter int          DIGIT_TO_CYC = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] tenkey,
    input  logic       close,
    output logic       lock,
    output logic       unlock_p,
    output logic       fail_p,
    output logic       lockout,
    output logic [3:0] tries_left
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_LOCKED  = 2'd0;
    localparam logic [1:0] ST_CHECK   = 2'd1;
    localparam logic [1:0] ST_OPEN    = 2'd2;
    localparam logic [1:0] ST_LOCKOUT = 2'd3;

    // One shared timer serves all states, so it is sized for the longest period.
    localparam int CMAX_A = (LOCKOUT_CYC > RELOCK_CYC) ? LOCKOUT_CYC : RELOCK_CYC;
    localparam int CMAX   = (CMAX_A > DIGIT_TO_CYC) ? CMAX_A : DIGIT_TO_CYC;
    localparam int CW     = $clog2(CMAX + 1);

    localparam logic [CW-1:0] DIGIT_LAST   = CW'(DIGIT_TO_CYC - 1);
    localparam logic [CW-1:0] RELOCK_LAST  = CW'(RELOCK_CYC - 1);
    localparam logic [CW-1:0] LOCKOUT_LAST = CW'(LOCKOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);

    localparam logic [3:0]  TRIES_INIT = 4'(MAX_TRIES);
    localparam logic [2:0]  IDX_LAST   = 3'(CODE_LEN - 1);

    // Only the top CODE_LEN nibbles take part in the comparison.
    localparam logic [31:0] MASK_FULL = (32'd1 << (4 * CODE_LEN)) - 32'd1;
    localparam logic [15:0] CODE_MASK = MASK_FULL[15:0] << (4 * (4 - CODE_LEN));

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]    state;
    logic [9:0]    tk_q;
    logic [2:0]    idx;
    logic [15:0]   dig_buf;
    logic [CW-1:0] cnt;

    // ------------------------------------------------------------------
    // Press detection and digit encoding
    // ------------------------------------------------------------------
    logic       key_onehot;
    logic       press;
    logic [3:0] key_digit;
    logic [4:0] ins_sh;
    logic [15:0] buf_ins;
    logic       code_ok;

    always_comb begin
        // x & (x-1) clears the lowest set bit; zero result means at most one bit set.
        key_onehot = (tenkey != 10'd0) && ((tenkey & (tenkey - 10'd1)) == 10'd0);
        key_digit  = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (tenkey[i]) begin
                key_digit = 4'(i);
            end
        end
        // A new press needs an all-zero sample before it, so held keys count once.
        press = key_onehot && (tk_q == 10'd0);
    end

    // First digit lands in the top nibble, so the buffer lines up with SECRET.
    always_comb begin
        ins_sh  = {IDX_LAST - idx, 2'b00} + 5'(4 * (4 - CODE_LEN));
        buf_ins = {12'd0, key_digit} << ins_sh;
        code_ok = ((dig_buf ^ SECRET) & CODE_MASK) == 16'd0;
    end

    // ------------------------------------------------------------------
    // Main sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_LOCKED;
            tk_q       <= 10'd0;
            idx        <= 3'd0;
            dig_buf    <= 16'd0;
            cnt        <= '0;
            lock       <= 1'b1;
            unlock_p   <= 1'b0;
            fail_p     <= 1'b0;
            lockout    <= 1'b0;
            tries_left <= TRIES_INIT;
        end else begin
            // tk_q tracks the keypad in every state so a key held across a
            // state change cannot be mistaken for a fresh press afterwards.
            tk_q     <= tenkey;
            unlock_p <= 1'b0;
            fail_p   <= 1'b0;

            case (state)
                ST_LOCKED: begin
                    lock    <= 1'b1;
                    lockout <= 1'b0;
                    if (close) begin
                        // close wins over a simultaneous press
                        idx     <= 3'd0;
                        dig_buf <= 16'd0;
                        cnt     <= '0;
                    end else if (press) begin
                        dig_buf <= dig_buf | buf_ins;
                        idx     <= idx + 3'd1;
                        cnt     <= '0;
                        if (idx == IDX_LAST) begin
                            state <= ST_CHECK;
                        end
                    end else if (idx != 3'd0) begin
                        // Inter-digit timeout abandons the entry silently.
                        if (cnt == DIGIT_LAST) begin
                            idx     <= 3'd0;
                            dig_buf <= 16'd0;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end

                ST_CHECK: begin
                    idx     <= 3'd0;
                    dig_buf <= 16'd0;
                    cnt     <= '0;
                    if (code_ok) begin
                        unlock_p   <= 1'b1;
                        tries_left <= TRIES_INIT;
                        lock       <= 1'b0;
                        state      <= ST_OPEN;
                    end else begin
                        fail_p     <= 1'b1;
                        tries_left <= tries_left - 4'd1;
                        // tries_left==1 means this failure uses the last attempt.
                        if (tries_left == 4'd1) begin
                            lockout <= 1'b1;
                            state   <= ST_LOCKOUT;
                        end else begin
                            state <= ST_LOCKED;
                        end
                    end
                end

                ST_OPEN: begin
                    if (close || (cnt == RELOCK_LAST)) begin
                        lock  <= 1'b1;
                        cnt   <= '0;
                        state <= ST_LOCKED;
                    end else begin
                        lock <= 1'b0;
                        cnt  <= cnt + CNT_ONE;
                    end
                end

                ST_LOCKOUT: begin
                    lock <= 1'b1;
                    if (cnt == LOCKOUT_LAST) begin
                        lockout    <= 1'b0;
                        tries_left <= TRIES_INIT;
                        cnt        <= '0;
                        state      <= ST_LOCKED;
                    end else begin
                        lockout <= 1'b1;
                        cnt     <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state <= ST_LOCKED;
                    lock  <= 1'b1;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elelock_ctrl.sv
// Self-checking bench for elelock_ctrl: scoreboard of expected result pulses plus direct output checks.
// Latency: expected pulse cycle = drive negedge count + 2.
// Backpressure: none.
module tb_elelock_ctrl;

    logic       clk;
    logic       rst_n;
    logic [9:0] tenkey;
    logic       close;
    logic       lock;
    logic       unlock_p;
    logic       fail_p;
    logic       lockout;
    logic [3:0] tries_left;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        bit is_unlock;
        int cyc;
    } exp_t;

    exp_t sb[$];

    elelock_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tenkey     (tenkey),
        .close      (close),
        .lock       (lock),
        .unlock_p   (unlock_p),
        .fail_p     (fail_p),
        .lockout    (lockout),
        .tries_left (tries_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pulse monitor: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (unlock_p || fail_p)) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_pulse", {30'd0, unlock_p, fail_p}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("pulse_unlock", {31'd0, unlock_p}, {31'd0, e.is_unlock});
                check_eq("pulse_fail", {31'd0, fail_p}, {31'd0, !e.is_unlock});
                check_eq("pulse_cycle", cyc, e.cyc);
                if (unlock_p) check_eq("lock_at_unlock", {31'd0, lock}, 32'd0);
            end
        end
    end

    // kind: 0 = no result expected, 1 = unlock, 2 = fail
    task automatic press(input int d, input int kind);
        @(negedge clk);
        tenkey = 10'd1 << d;
        if (kind != 0) sb.push_back('{is_unlock: (kind == 1), cyc: cyc + 2});
        @(negedge clk);
        tenkey = 10'd0;
    endtask

    task automatic enter(input logic [15:0] code, input int kind);
        for (int i = 0; i < 4; i++) begin
            press(int'(code[15-4*i -: 4]), (i == 3) ? kind : 0);
        end
    endtask

    task automatic pulse_close();
        @(negedge clk);
        close = 1'b1;
        @(negedge clk);
        close = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_lock"}, {31'd0, lock}, 32'd1);
        check_eq({tag, "_unlock_p"}, {31'd0, unlock_p}, 32'd0);
        check_eq({tag, "_fail_p"}, {31'd0, fail_p}, 32'd0);
        check_eq({tag, "_lockout"}, {31'd0, lockout}, 32'd0);
        check_eq({tag, "_tries"}, {28'd0, tries_left}, 32'd3);
    endtask

    task automatic three_fails();
        for (int k = 0; k < 3; k++) begin
            enter(16'h3718, 2);
            @(negedge clk);
            check_eq("tries_after_fail", {28'd0, tries_left}, 32'(2 - k));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lstart;
        int e;
        rst_n  = 1'b0;
        tenkey = 10'd0;
        close  = 1'b0;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Correct code, then auto-relock exactly RELOCK_CYC edges after OPEN entry.
        enter(16'h3719, 1);
        @(negedge clk);
        e = cyc;
        check_eq("open_lock", {31'd0, lock}, 32'd0);
        check_eq("open_tries", {28'd0, tries_left}, 32'd3);
        wait_until(e + 499);
        check_eq("relock_early", {31'd0, lock}, 32'd0);
        wait_until(e + 500);
        check_eq("relock_due", {31'd0, lock}, 32'd1);

        // Three wrong codes -> lockout; correct code ignored during lockout.
        three_fails();
        lstart = cyc;
        check_eq("lockout_set", {31'd0, lockout}, 32'd1);
        check_eq("lockout_lock", {31'd0, lock}, 32'd1);
        enter(16'h3719, 0);
        pulse_close();
        check_eq("lockout_ignores_keys", {31'd0, lock}, 32'd1);
        wait_until(lstart + 999);
        check_eq("lockout_still", {31'd0, lockout}, 32'd1);
        wait_until(lstart + 1000);
        check_eq("lockout_end", {31'd0, lockout}, 32'd0);
        check_eq("lockout_end_tries", {28'd0, tries_left}, 32'd3);
        enter(16'h3719, 1);
        @(negedge clk);
        check_eq("post_lockout_open", {31'd0, lock}, 32'd0);
        pulse_close();
        check_eq("close_relock", {31'd0, lock}, 32'd1);

        // Held key counts once.
        @(negedge clk);
        tenkey = 10'b0000001000;
        repeat (20) @(negedge clk);
        tenkey = 10'd0;
        press(7, 0);
        press(1, 0);
        press(9, 1);
        @(negedge clk);
        check_eq("held_key_open", {31'd0, lock}, 32'd0);
        pulse_close();

        // Multi-bit value is not a digit.
        @(negedge clk);
        tenkey = 10'b0000001010;
        repeat (5) @(negedge clk);
        tenkey = 10'd0;
        enter(16'h3719, 1);
        @(negedge clk);
        check_eq("multibit_open", {31'd0, lock}, 32'd0);
        pulse_close();

        // Inter-digit gap just under the timeout keeps the entry.
        press(3, 0);
        press(7, 0);
        repeat (197) @(negedge clk);
        press(1, 0);
        press(9, 1);
        @(negedge clk);
        check_eq("gap_under_timeout_open", {31'd0, lock}, 32'd0);
        pulse_close();

        // Gap past the timeout discards 3,7 silently.
        press(3, 0);
        press(7, 0);
        repeat (199) @(negedge clk);
        enter(16'h3719, 1);
        @(negedge clk);
        check_eq("timeout_open", {31'd0, lock}, 32'd0);
        check_eq("timeout_tries", {28'd0, tries_left}, 32'd3);
        pulse_close();

        // close mid-entry clears it; 1,9 alone never reaches CHECK.
        press(3, 0);
        press(7, 0);
        pulse_close();
        press(1, 0);
        press(9, 0);
        repeat (4) @(negedge clk);
        check_eq("close_clear_locked", {31'd0, lock}, 32'd1);
        pulse_close();
        enter(16'h3719, 1);
        @(negedge clk);
        check_eq("close_then_open", {31'd0, lock}, 32'd0);
        @(negedge clk);
        close = 1'b1;
        @(negedge clk);
        close = 1'b0;
        check_eq("close_next_edge", {31'd0, lock}, 32'd1);

        // Reset mid-entry after one failure.
        enter(16'h3718, 2);
        @(negedge clk);
        check_eq("pre_reset_tries", {28'd0, tries_left}, 32'd2);
        press(3, 0);
        press(7, 0);
        #3 rst_n = 1'b0;
        #1 check_reset_vals("rst_mid_entry");
        @(negedge clk);
        rst_n = 1'b1;
        enter(16'h3719, 1);
        @(negedge clk);
        check_eq("rst_entry_open", {31'd0, lock}, 32'd0);
        pulse_close();

        // Reset during lockout.
        three_fails();
        check_eq("lockout2_set", {31'd0, lockout}, 32'd1);
        repeat (50) @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_vals("rst_lockout");
        @(negedge clk);
        rst_n = 1'b1;
        enter(16'h3719, 1);
        @(negedge clk);
        check_eq("rst_lockout_open", {31'd0, lock}, 32'd0);
        pulse_close();

        repeat (5) @(negedge clk);
        check_eq("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
